// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch funct3 codes,
// 2-bit BHT counter encodings and helpers for condition evaluation and counter update.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e BHT_RST_VAL = WNT;

  // Flags come from rs1 + ~rs2 + 1, so cf=1 means rs1 >= rs2 unsigned.
  function automatic logic br_cond(input logic [2:0] f3, input logic cf, input logic zf,
                                   input logic vf, input logic sf);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = zf;
      F3_BNE:  t = ~zf;
      F3_BLT:  t = sf ^ vf;
      F3_BGE:  t = ~(sf ^ vf);
      F3_BLTU: t = ~cf;
      F3_BGEU: t = cf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic bht_ctr_e ctr_next(input bht_ctr_e c, input logic taken);
    bht_ctr_e n;
    n = c;
    if (taken) begin
      case (c)
        SNT:     n = WNT;
        WNT:     n = WT;
        default: n = ST;
      endcase
    end else begin
      case (c)
        ST:      n = WT;
        WT:      n = WNT;
        default: n = SNT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Array of 2-bit saturating counters; combinational read (pre-update value), write at the clock edge.
// Latency: read 0 cycles, update visible the cycle after wr_en; no backpressure.
module branch_history_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_ctr_e   ctr_q [ENTRIES];
  bht_ctr_e   ctr_d [ENTRIES];
  logic [1:0] rd_ctr;

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

  assign rd_ctr   = ctr_q[rd_idx];
  assign rd_taken = rd_ctr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_RST_VAL;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps from ALU flags, flags mispredicts and owns the BHT.
// Latency: flush/redirect one cycle after resolution; stall holds EX (no resolve). Macro BRU_PERF_CNT_EN adds perf counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [2:0]      ex_funct3,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic            stall,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            resolved_taken,
  output logic            illegal_br,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            flush_q, flush_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic            resolved_q, resolved_d;
  logic            illegal_q, illegal_d;
  logic            resolve, taken, mispredict, br_upd, unused_lookup_bits;

  // Wrong-path instructions behind a pending flush must never resolve.
  assign resolve    = ex_valid & ~stall & ~flush_q & (ex_is_branch | ex_is_jump);
  assign taken      = ex_is_jump | (ex_is_branch & br_cond(ex_funct3, cf, zf, vf, sf));
  assign mispredict = resolve & (taken != ex_pred_taken);
  assign br_upd     = resolve & ~ex_is_jump;

  always_comb begin
    flush_d    = mispredict;
    redirect_d = redirect_q;
    resolved_d = resolved_q;
    illegal_d  = br_upd & (ex_funct3[2:1] == 2'b01);
    if (mispredict) begin
      redirect_d = taken ? ex_target : ex_pc + PC_W'(4);
    end
    if (resolve) begin
      resolved_d = taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      resolved_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      resolved_q <= resolved_d;
      illegal_q  <= illegal_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign resolved_taken = resolved_q;
  assign illegal_br     = illegal_q;

  branch_history_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (lookup_pc[IDX_W+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (br_upd),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign unused_lookup_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (br_upd && perf_br_q != 32'hFFFF_FFFF) begin
      perf_br_d = perf_br_q + 32'd1;
    end
    if (mispredict && perf_mis_q != 32'hFFFF_FFFF) begin
      perf_mis_d = perf_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against an operand-level reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken, stall;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target;
  logic        cf, zf, vf, sf;
  logic        flush, resolved_taken, illegal_br;
  logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

  // ALU operands; flags derived as the ALU would for rs1 - rs2
  logic [31:0] op_a, op_b;
  logic [32:0] alu_sum;

  always #5 clk = ~clk;

  always_comb begin
    alu_sum = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
    cf = alu_sum[32];
    zf = (alu_sum[31:0] == 32'd0);
    sf = alu_sum[31];
    vf = (op_a[31] != op_b[31]) && (alu_sum[31] != op_a[31]);
  end

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .cf(cf), .zf(zf), .vf(vf), .sf(sf),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .resolved_taken(resolved_taken), .illegal_br(illegal_br),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  int          errors = 0;
  int          checks = 0;
  int          m_cnt [16];
  bit          m_flush, m_resolved, m_illegal;
  logic [31:0] m_redirect;
  int unsigned m_nbr, m_nmis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd15);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_cnt[bidx(pc)] >= 2;
  endfunction

  task automatic m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 1;
    m_flush = 0; m_resolved = 0; m_illegal = 0; m_redirect = 0;
    m_nbr = 0; m_nmis = 0;
  endtask

  task automatic drv(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                     input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                     input logic [31:0] a, input logic [31:0] b, input bit stl);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; op_a = a; op_b = b; stall = stl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'd0, 32'd1, 0);
  endtask

  // One clock: check the lookup before the edge, then all registered outputs after it.
  task automatic cyc();
    bit          res, tk, mis;
    logic [31:0] nxt_redir;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(lookup_pc)});
    res = ex_valid && !stall && !m_flush && (ex_is_branch || ex_is_jump);
    tk  = ex_is_jump ? 1'b1 : ref_taken(ex_funct3, op_a, op_b);
    mis = res && (tk != ex_pred_taken);
    nxt_redir = mis ? (tk ? ex_target : ex_pc + 32'd4) : m_redirect;
    @(posedge clk);
    #1;
    m_flush    = mis;
    m_redirect = nxt_redir;
    if (res) m_resolved = tk;
    m_illegal = res && !ex_is_jump && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
    if (res && !ex_is_jump) begin
      m_nbr++;
      if (tk) m_cnt[bidx(ex_pc)] = (m_cnt[bidx(ex_pc)] == 3) ? 3 : m_cnt[bidx(ex_pc)] + 1;
      else    m_cnt[bidx(ex_pc)] = (m_cnt[bidx(ex_pc)] == 0) ? 0 : m_cnt[bidx(ex_pc)] - 1;
    end
    if (mis) m_nmis++;
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("redirect_pc", redirect_pc, m_redirect);
    chk("resolved_taken", {31'd0, resolved_taken}, {31'd0, m_resolved});
    chk("illegal_br", {31'd0, illegal_br}, {31'd0, m_illegal});
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", perf_branches, m_nbr);
    chk("perf_mispredicts", perf_mispredicts, m_nmis);
`else
    chk("perf_branches", perf_branches, 32'd0);
    chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_pc = 32'h0;
    idle();
    m_reset();
    #22;
    for (int i = 0; i < 16; i++) begin
      lookup_pc = i * 4;
      #1;
      chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    end
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_resolved", {31'd0, resolved_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken, predicted not-taken
    lookup_pc = 32'h100;
    drv(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 32'd7, 32'd7, 0);
    cyc();
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h140);
    chk("beq_taken", {31'd0, resolved_taken}, 32'd1);
    idle();
    cyc();
    chk("flush_one_cycle", {31'd0, flush}, 32'd0);
    chk("redirect_hold", redirect_pc, 32'h140);

    // BLT taken as predicted, then BLTU not taken but predicted taken
    drv(1, 1, 0, 3'd4, 32'h180, 32'h1C0, 1, 32'hFFFF_FFFF, 32'd0, 0);
    cyc();
    chk("blt_no_flush", {31'd0, flush}, 32'd0);
    drv(1, 1, 0, 3'd6, 32'h184, 32'h1C0, 1, 32'd5, 32'd3, 0);
    cyc();
    chk("bltu_flush", {31'd0, flush}, 32'd1);
    chk("bltu_redirect", redirect_pc, 32'h188);
    idle();
    cyc();

    // Train 0x200: four taken, then three not-taken
    lookup_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 0, 3'd0, 32'h200, 32'h300, 1, 32'd1, 32'd1, 0);
      cyc();
      idle();
      cyc();
    end
    chk("bht_saturated_taken", {31'd0, pred_taken}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 3'd0, 32'h200, 32'h300, 0, 32'd1, 32'd2, 0);
      cyc();
      idle();
      cyc();
    end
    chk("bht_trained_not_taken", {31'd0, pred_taken}, 32'd0);

    // Back-to-back: branch right after a mispredict is wrong-path
    lookup_pc = 32'h300;
    drv(1, 1, 0, 3'd1, 32'h240, 32'h280, 0, 32'd1, 32'd2, 0);
    cyc();
    drv(1, 1, 0, 3'd0, 32'h300, 32'h380, 0, 32'd4, 32'd4, 0);
    cyc();
    chk("b2b_no_second_flush", {31'd0, flush}, 32'd0);
    chk("b2b_redirect", redirect_pc, 32'h280);
    idle();
    cyc();
    chk("b2b_bht_untouched", {31'd0, pred_taken}, 32'd0);

    // Stalled mispredict does not resolve
    drv(1, 1, 0, 3'd0, 32'h300, 32'h380, 0, 32'd4, 32'd4, 1);
    cyc();
    chk("stall_no_flush", {31'd0, flush}, 32'd0);

    // Illegal funct3 and PC wrap
    drv(1, 1, 0, 3'd2, 32'h400, 32'h500, 1, 32'd0, 32'd0, 0);
    cyc();
    chk("illegal_pulse", {31'd0, illegal_br}, 32'd1);
    chk("illegal_redirect", redirect_pc, 32'h404);
    idle();
    cyc();
    chk("illegal_one_cycle", {31'd0, illegal_br}, 32'd0);
    drv(1, 1, 0, 3'd0, 32'hFFFF_FFFC, 32'h10, 1, 32'd1, 32'd9, 0);
    cyc();
    chk("wrap_redirect", redirect_pc, 32'h0);
    idle();
    cyc();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, b, pc;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {a[31] ^ 1'b1, a[30:0]};
      pc = ($urandom_range(0, 30) == 0) ? 32'hFFFF_FFFC : 32'h1000 + ($urandom_range(0, 63) << 2);
      drv($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
          3'($urandom_range(0, 7)), pc, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
          a, b, $urandom_range(0, 4) == 0);
      lookup_pc = 32'h1000 + ($urandom_range(0, 63) << 2);
      cyc();
    end

    // Reset in the middle of a pending flush
    drv(1, 0, 1, 3'd0, 32'h600, 32'h700, 0, 32'd0, 32'd0, 0);
    cyc();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_redirect", redirect_pc, 32'd0);
    chk("midrst_resolved", {31'd0, resolved_taken}, 32'd0);
    chk("midrst_perf", perf_mispredicts, 32'd0);
    m_reset();
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h1000 + i * 4;
      #1;
      chk("midrst_pred", {31'd0, pred_taken}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
